// File: rtl/fir_pkg.sv
// Shared constants, state encoding and helpers for the time-multiplexed FIR stage.
// Coefficients are the 16 unique taps of the symmetric 31-tap low-pass, scaled by 2^SHIFT.
package fir_pkg;

  localparam int DATA_W = 10;
  localparam int NTAPS  = 31;
  localparam int NHALF  = (NTAPS + 1) / 2;
  localparam int COEF_W = 8;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 10;
  localparam int PTR_W  = $clog2(NTAPS);
  localparam int K_W    = $clog2(NHALF);
  localparam int PROD_W = COEF_W + DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    SCALE = 2'd2
  } state_t;

  localparam logic [COEF_W-1:0] COEF [NHALF] = '{
    8'd3,  8'd4,  8'd6,  8'd8,  8'd12, 8'd17, 8'd23, 8'd29,
    8'd36, 8'd43, 8'd50, 8'd56, 8'd61, 8'd65, 8'd67, 8'd68
  };

  // Scale down and clamp to full scale instead of letting the high bits wrap.
  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] s;
    s = acc >> SHIFT;
    if (s > ACC_W'((1 << DATA_W) - 1)) return '1;
    return s[DATA_W-1:0];
  endfunction

  // Reduce an index known to lie in [0, 2*NTAPS) to [0, NTAPS).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W:0] i);
    if (i >= (PTR_W+1)'(NTAPS)) return PTR_W'(i - (PTR_W+1)'(NTAPS));
    return i[PTR_W-1:0];
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: one write port, two combinational taps at +/- offsets from
// the newest sample, so tap k pairs x[newest-k] with x[newest-(NTAPS-1-k)].
module fir_sample_ring
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] ring [NTAPS];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  newest;
  logic [PTR_W-1:0]  idx_a;
  logic [PTR_W-1:0]  idx_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) ring[i] <= '0;
      wr_ptr <= '0;
      newest <= '0;
    end else if (wr_en) begin
      ring[wr_ptr] <= wr_data;
      newest       <= wr_ptr;
      wr_ptr       <= (wr_ptr == PTR_W'(NTAPS - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // newest-(NTAPS-1-k) mod NTAPS is the same slot as newest+1+k mod NTAPS.
  always_comb begin
    idx_a = wrap_idx({1'b0, newest} + (PTR_W+1)'(NTAPS) - (PTR_W+1)'(k));
    idx_b = wrap_idx({1'b0, newest} + (PTR_W+1)'(1) + (PTR_W+1)'(k));
  end

  assign rd_a = ring[idx_a];
  assign rd_b = ring[idx_b];

endmodule

// File: rtl/fir_mac_scheduler.sv
// Folded symmetric FIR on one multiplier: accept a sample in IDLE, run NHALF MAC cycles,
// then scale/saturate and pulse filt_valid. Handshake: a sample is taken on any edge where
// sample_valid and sample_ready are both high; a strobe while sample_ready is low is dropped
// and flagged in the sticky overrun bit.
module fir_mac_scheduler
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] filt_out,
  output logic              filt_valid,
  output logic              busy,
  output logic              overrun,
  output state_t            fsm_state
);

  localparam logic [K_W-1:0] K_LAST = K_W'(NHALF - 1);

  state_t            state;
  logic [K_W-1:0]    k;
  logic [ACC_W-1:0]  acc;
  logic              accept;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W:0]   pre_add;
  logic [PROD_W-1:0] product;

  assign accept       = (state == IDLE) && sample_valid;
  assign sample_ready = (state == IDLE);
  assign busy         = (state == MAC) || (state == SCALE);
  assign fsm_state    = state;

  fir_sample_ring u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (sample_in),
    .k       (k),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  // Centre tap has no mirror partner; both read ports land on the same slot there.
  always_comb begin
    pre_add = (k == K_LAST) ? {1'b0, rd_a} : ({1'b0, rd_a} + {1'b0, rd_b});
    product = PROD_W'(COEF[k]) * PROD_W'(pre_add);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      acc        <= '0;
      filt_out   <= '0;
      filt_valid <= 1'b0;
    end else begin
      filt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(product);
          if (k == K_LAST) state <= SCALE;
          else             k     <= k + 1'b1;
        end
        SCALE: begin
          filt_out   <= saturate(acc);
          filt_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               overrun <= 1'b0;
    else if (sample_valid && !sample_ready)  overrun <= 1'b1;
    else if (clr_overrun)                    overrun <= 1'b0;
  end

endmodule
